// File: rtl/cpu_common_pkg.sv
// ----------------------------------------------------------------------------
// cpu_common
//   Types and constants shared between the CPU control FSM and the
//   instruction fetch unit.
//
//   fetch_operation_t : command from control to the fetch unit
//                       (FETCH_NOP / FETCH_INC_PC / FETCH_LOAD_PC)
//   fetch_state_t     : fetch unit sequencing state (FETCHING / DONE)
//   DEFAULT_PC_WIDTH  : default program counter / instruction address width
//   DEFAULT_INSTR_BYTES : default instruction length in bytes
// ----------------------------------------------------------------------------
package cpu_common;

   localparam int DEFAULT_PC_WIDTH    = 16;
   localparam int DEFAULT_INSTR_BYTES = 2;

   typedef enum logic [1:0] {
      FETCH_NOP     = 2'd0,
      FETCH_INC_PC  = 2'd1,
      FETCH_LOAD_PC = 2'd2
   } fetch_operation_t;

   typedef enum logic {
      FETCHING = 1'b0,
      DONE     = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch unit. Owns the program counter and reads INSTR_BYTES
//   bytes per instruction from a synchronous byte-wide instruction memory,
//   one read per cycle with the captures trailing the issues by one cycle.
//   The assembled instruction (byte at pc in the MSBs) is presented together
//   with the level signal fetch_complete, which control uses as decode_en.
//
//   Ports:
//     clk             in   sole clock, rising edge
//     rst_async       in   asynchronous active-high reset
//     fetch_operation in   FETCH_NOP / FETCH_INC_PC / FETCH_LOAD_PC, sampled
//                          every rising edge
//     new_pc          in   jump target for FETCH_LOAD_PC
//     fetch_complete  out  instruction valid for current pc (registered)
//     instruction     out  assembled instruction, 8*INSTR_BYTES bits
//     pc              out  address of the current instruction
//     mem_addr        out  instruction memory read address
//     mem_rd_en       out  instruction memory read strobe
//     mem_rd_data     in   read data, valid the cycle after addr/strobe
//
//   Build option:
//     FETCH_BRANCH_ABORT_EN  when defined, FETCH_LOAD_PC during FETCHING
//                            aborts the current fetch and restarts at
//                            new_pc; otherwise every op other than
//                            FETCH_NOP is ignored while fetching.
// ----------------------------------------------------------------------------
module fetch_unit
   import cpu_common::*;
#(
   parameter int                    PC_WIDTH    = DEFAULT_PC_WIDTH,
   parameter int                    INSTR_BYTES = DEFAULT_INSTR_BYTES,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
   input  logic                     clk,
   input  logic                     rst_async,
   input  fetch_operation_t         fetch_operation,
   input  logic [PC_WIDTH-1:0]      new_pc,
   output logic                     fetch_complete,
   output logic [8*INSTR_BYTES-1:0] instruction,
   output logic [PC_WIDTH-1:0]      pc,
   output logic [PC_WIDTH-1:0]      mem_addr,
   output logic                     mem_rd_en,
   input  logic [7:0]               mem_rd_data
);

   // Index counters must be able to hold INSTR_BYTES (issue_idx terminal value)
   localparam int                  IDX_W     = $clog2(INSTR_BYTES + 1);
   localparam logic [IDX_W-1:0]    NUM_BYTES = IDX_W'(INSTR_BYTES);
   localparam logic [IDX_W-1:0]    LAST_BYTE = IDX_W'(INSTR_BYTES - 1);
   localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(INSTR_BYTES);

   fetch_state_t             state_q, state_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic [8*INSTR_BYTES-1:0] instr_q, instr_d;
   logic                     complete_q, complete_d;
   logic [IDX_W-1:0]         issue_idx_q, issue_idx_d;
   logic [IDX_W-1:0]         cap_idx_q, cap_idx_d;
   logic                     cap_pending_q, cap_pending_d;

   logic                     issuing;
   logic                     abort;
   logic                     restart;

   // A read goes out every FETCHING cycle until all bytes have been issued
   assign issuing   = (state_q == FETCHING) && (issue_idx_q < NUM_BYTES);
   assign mem_rd_en = issuing;
   assign mem_addr  = issuing ? (pc_q + PC_WIDTH'(issue_idx_q)) : pc_q;

`ifdef FETCH_BRANCH_ABORT_EN
   assign abort = (state_q == FETCHING) && (fetch_operation == FETCH_LOAD_PC);
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      complete_d    = complete_q;
      issue_idx_d   = issue_idx_q;
      cap_idx_d     = cap_idx_q;
      cap_pending_d = 1'b0;
      restart       = 1'b0;

      case (state_q)
         FETCHING: begin
            if (abort) begin
               // In-flight byte belongs to the abandoned fetch: not captured
               pc_d    = new_pc;
               restart = 1'b1;
            end else begin
               if (issuing) begin
                  issue_idx_d   = issue_idx_q + IDX_W'(1);
                  cap_pending_d = 1'b1;
               end
               if (cap_pending_q) begin
                  // Byte 0 lands in the most significant lane
                  for (int b = 0; b < INSTR_BYTES; b++) begin
                     if (cap_idx_q == IDX_W'(b)) begin
                        instr_d[(INSTR_BYTES-1-b)*8 +: 8] = mem_rd_data;
                     end
                  end
                  if (cap_idx_q == LAST_BYTE) begin
                     state_d    = DONE;
                     complete_d = 1'b1;
                  end else begin
                     cap_idx_d = cap_idx_q + IDX_W'(1);
                  end
               end
            end
         end
         DONE: begin
            case (fetch_operation)
               FETCH_INC_PC: begin
                  pc_d    = pc_q + PC_STEP;
                  restart = 1'b1;
               end
               FETCH_LOAD_PC: begin
                  pc_d    = new_pc;
                  restart = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase

      // instruction is deliberately left alone so it holds until overwritten
      if (restart) begin
         state_d       = FETCHING;
         issue_idx_d   = '0;
         cap_idx_d     = '0;
         cap_pending_d = 1'b0;
         complete_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_q       <= FETCHING;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         complete_q    <= 1'b0;
         issue_idx_q   <= '0;
         cap_idx_q     <= '0;
         cap_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         complete_q    <= complete_d;
         issue_idx_q   <= issue_idx_d;
         cap_idx_q     <= cap_idx_d;
         cap_pending_q <= cap_pending_d;
      end
   end

   assign fetch_complete = complete_q;
   assign instruction    = instr_q;
   assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import cpu_common::*;

   logic             clk;
   logic             rst_async;
   fetch_operation_t fetch_operation;
   logic [15:0]      new_pc;
   logic             fetch_complete;
   logic [15:0]      instruction;
   logic [15:0]      pc;
   logic [15:0]      mem_addr;
   logic             mem_rd_en;
   logic [7:0]       mem_rd_data;

   logic [7:0]       mem [0:65535];

   int n_tests;
   int n_fail;

   fetch_unit #(
      .PC_WIDTH    (16),
      .INSTR_BYTES (2),
      .RESET_PC    (16'h0000)
   ) dut (
      .clk             (clk),
      .rst_async       (rst_async),
      .fetch_operation (fetch_operation),
      .new_pc          (new_pc),
      .fetch_complete  (fetch_complete),
      .instruction     (instruction),
      .pc              (pc),
      .mem_addr        (mem_addr),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_data     (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte-wide instruction memory
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
   end

   // Drive an op for exactly one rising edge; returns at the negedge after it
   task automatic issue_op(input fetch_operation_t op, input logic [15:0] target);
      fetch_operation = op;
      new_pc          = target;
      @(negedge clk);
      fetch_operation = FETCH_NOP;
   endtask

   task automatic test_reset();
      n_tests++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL rst_complete: got %0b expected 0", fetch_complete); end
      n_tests++; if (instruction !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h expected 0000", instruction); end
      n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h expected 0000", pc); end
      n_tests++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL rst_rd_en: got %0b expected 1", mem_rd_en); end
      n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", mem_addr); end
      rst_async = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL rst_early_complete: got %0b expected 0", fetch_complete); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1) begin n_fail++; $display("FAIL rst_first_complete: got %0b expected 1", fetch_complete); end
      n_tests++; if (instruction !== 16'hA1B2) begin n_fail++; $display("FAIL rst_first_instr: got %h expected a1b2", instruction); end
      n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_first_pc: got %h expected 0000", pc); end
      n_tests++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_done_rd_en: got %0b expected 0", mem_rd_en); end
   endtask

   task automatic test_sequential();
      issue_op(FETCH_INC_PC, 16'h0000);
      n_tests++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL seq_drop: got %0b expected 0", fetch_complete); end
      n_tests++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0002) begin n_fail++; $display("FAIL seq_addr0: got en=%0b addr=%h expected en=1 addr=0002", mem_rd_en, mem_addr); end
      @(negedge clk);
      n_tests++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0003) begin n_fail++; $display("FAIL seq_addr1: got en=%0b addr=%h expected en=1 addr=0003", mem_rd_en, mem_addr); end
      @(negedge clk);
      n_tests++; if (mem_rd_en !== 1'b0 || fetch_complete !== 1'b0) begin n_fail++; $display("FAIL seq_cycle3: got en=%0b cmp=%0b expected en=0 cmp=0", mem_rd_en, fetch_complete); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1) begin n_fail++; $display("FAIL seq_complete: got %0b expected 1", fetch_complete); end
      n_tests++; if (instruction !== 16'hC3D4) begin n_fail++; $display("FAIL seq_instr: got %h expected c3d4", instruction); end
      n_tests++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL seq_pc: got %h expected 0002", pc); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++;
         if (mem_rd_en !== 1'b0 || fetch_complete !== 1'b1 || instruction !== 16'hC3D4 || pc !== 16'h0002) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got en=%0b cmp=%0b instr=%h pc=%h expected en=0 cmp=1 instr=c3d4 pc=0002",
                     i, mem_rd_en, fetch_complete, instruction, pc);
         end
      end
   endtask

   task automatic test_jump();
      issue_op(FETCH_LOAD_PC, 16'h1234);
      n_tests++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h1234) begin n_fail++; $display("FAIL jump_addr0: got en=%0b addr=%h expected en=1 addr=1234", mem_rd_en, mem_addr); end
      n_tests++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL jump_pc_early: got %h expected 1234", pc); end
      @(negedge clk);
      n_tests++; if (mem_addr !== 16'h1235) begin n_fail++; $display("FAIL jump_addr1: got %h expected 1235", mem_addr); end
      repeat (2) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'h5A6B || pc !== 16'h1234) begin n_fail++; $display("FAIL jump_result: got cmp=%0b instr=%h pc=%h expected cmp=1 instr=5a6b pc=1234", fetch_complete, instruction, pc); end
   endtask

   task automatic test_wrap();
      issue_op(FETCH_LOAD_PC, 16'hFFFF);
      n_tests++; if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr0: got %h expected ffff", mem_addr); end
      @(negedge clk);
      n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 0000", mem_addr); end
      repeat (2) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'hE7A1 || pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_result: got cmp=%0b instr=%h pc=%h expected cmp=1 instr=e7a1 pc=ffff", fetch_complete, instruction, pc); end
      issue_op(FETCH_INC_PC, 16'h0000);
      n_tests++; if (pc !== 16'h0001 || mem_addr !== 16'h0001) begin n_fail++; $display("FAIL wrap_inc: got pc=%h addr=%h expected pc=0001 addr=0001", pc, mem_addr); end
      repeat (3) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'hB2C3) begin n_fail++; $display("FAIL wrap_inc_result: got cmp=%0b instr=%h expected cmp=1 instr=b2c3", fetch_complete, instruction); end
   endtask

   task automatic test_branch_mid_fetch();
      issue_op(FETCH_LOAD_PC, 16'h0100);
      @(negedge clk);
      // Now in cycle 2 of the fetch at 0x0100
      issue_op(FETCH_LOAD_PC, 16'h0040);
`ifdef FETCH_BRANCH_ABORT_EN
      n_tests++; if (pc !== 16'h0040 || mem_rd_en !== 1'b1 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL abort_restart: got pc=%h en=%0b addr=%h expected pc=0040 en=1 addr=0040", pc, mem_rd_en, mem_addr); end
      @(negedge clk);
      n_tests++; if (mem_addr !== 16'h0041) begin n_fail++; $display("FAIL abort_addr1: got %h expected 0041", mem_addr); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL abort_early_complete: got %0b expected 0", fetch_complete); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'h7788 || pc !== 16'h0040) begin n_fail++; $display("FAIL abort_result: got cmp=%0b instr=%h pc=%h expected cmp=1 instr=7788 pc=0040", fetch_complete, instruction, pc); end
`else
      n_tests++; if (pc !== 16'h0100 || mem_rd_en !== 1'b0 || fetch_complete !== 1'b0) begin n_fail++; $display("FAIL noabort_ignored: got pc=%h en=%0b cmp=%0b expected pc=0100 en=0 cmp=0", pc, mem_rd_en, fetch_complete); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'h1122 || pc !== 16'h0100) begin n_fail++; $display("FAIL noabort_result: got cmp=%0b instr=%h pc=%h expected cmp=1 instr=1122 pc=0100", fetch_complete, instruction, pc); end
      repeat (2) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || mem_rd_en !== 1'b0 || pc !== 16'h0100) begin n_fail++; $display("FAIL noabort_stable: got cmp=%0b en=%0b pc=%h expected cmp=1 en=0 pc=0100", fetch_complete, mem_rd_en, pc); end
`endif
   endtask

   task automatic test_reset_mid_fetch();
      issue_op(FETCH_INC_PC, 16'h0000);
      @(negedge clk);
      rst_async = 1'b1;
      #1;
      n_tests++; if (pc !== 16'h0000 || instruction !== 16'h0000 || fetch_complete !== 1'b0) begin n_fail++; $display("FAIL midrst_values: got pc=%h instr=%h cmp=%0b expected pc=0000 instr=0000 cmp=0", pc, instruction, fetch_complete); end
      n_tests++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL midrst_mem: got en=%0b addr=%h expected en=1 addr=0000", mem_rd_en, mem_addr); end
      @(negedge clk);
      rst_async = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %0b expected 0", fetch_complete); end
      @(negedge clk);
      n_tests++; if (fetch_complete !== 1'b1 || instruction !== 16'hA1B2 || pc !== 16'h0000) begin n_fail++; $display("FAIL midrst_result: got cmp=%0b instr=%h pc=%h expected cmp=1 instr=a1b2 pc=0000", fetch_complete, instruction, pc); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0000] = 8'hA1; mem[16'h0001] = 8'hB2;
      mem[16'h0002] = 8'hC3; mem[16'h0003] = 8'hD4;
      mem[16'h1234] = 8'h5A; mem[16'h1235] = 8'h6B;
      mem[16'hFFFF] = 8'hE7;
      mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
      mem[16'h0040] = 8'h77; mem[16'h0041] = 8'h88;

      rst_async       = 1'b1;
      fetch_operation = FETCH_NOP;
      new_pc          = 16'h0000;
      repeat (2) @(negedge clk);

      test_reset();
      test_sequential();
      test_hold();
      test_jump();
      test_wrap();
      test_branch_mid_fetch();
      test_reset_mid_fetch();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the CPU: the responder side of the `fetch_operation` / `fetch_complete` handshake driven by the control FSM. It owns the program counter and reads an instruction of `INSTR_BYTES` bytes from synchronous, byte-wide instruction memory, one byte per cycle, pipelined. It assembles the bytes into `instruction` and raises `fetch_complete` when the instruction is valid. Control samples that signal in FETCH and uses it as `decode_en`.

## Interface
- `PC_WIDTH`, 16, program counter and memory address width
- `INSTR_BYTES`, 2, bytes per instruction (≥1)
- `RESET_PC`, 0, PC value loaded on reset
- `clk` in 1: sole clock, rising edge
- `rst_async` in 1: reset, asynchronous, active-high
- `fetch_operation` in `fetch_operation_t`: FETCH_NOP / FETCH_INC_PC / FETCH_LOAD_PC, sampled every rising edge
- `new_pc` in PC_WIDTH: target for FETCH_LOAD_PC
- `fetch_complete` out 1: `instruction` valid for current `pc` (registered, level)
- `instruction` out 8·INSTR_BYTES: assembled instruction, byte at `pc` in MSBs
- `pc` out PC_WIDTH: address of current instruction
- `mem_addr` out PC_WIDTH: instruction memory read address
- `mem_rd_en` out 1: read strobe
- `mem_rd_data` in 8: read data, valid the cycle after the address/strobe

## Operation
- States: FETCHING, DONE.
- Counters:
  - `issue_idx` runs 0..INSTR_BYTES.
  - `cap_idx` runs 0..INSTR_BYTES-1.
  - A one-bit `cap_pending` marks a read issued last cycle.
- FETCHING:
  - While `issue_idx < INSTR_BYTES`: `mem_rd_en=1`, `mem_addr = pc + issue_idx` (mod 2^PC_WIDTH), `issue_idx++`.
  - Each cycle with `cap_pending=1`: capture `mem_rd_data` into byte lane `cap_idx`, then `cap_idx++`.
  - Byte 0 goes to `instruction[8·INSTR_BYTES-1 -: 8]`.
  - After the last byte is captured: go to DONE, set `fetch_complete=1`.
- DONE:
  - `mem_rd_en=0`, `mem_addr` don't-care (drive `pc`).
  - FETCH_NOP: hold everything.
  - FETCH_INC_PC: `pc <= pc + INSTR_BYTES` (wraps), then restart.
  - FETCH_LOAD_PC: `pc <= new_pc`, then restart.
- Restart:
  - State FETCHING, `issue_idx=0`, `cap_idx=0`, `cap_pending=0`, `fetch_complete=0`.
  - `instruction` keeps its old value until it is overwritten.
- FETCH_INC_PC during FETCHING is a protocol violation and is ignored.
- FETCH_LOAD_PC during FETCHING: see Configuration.
- Address wrap:
  - `pc + i` wraps modulo 2^PC_WIDTH.
  - Example: `pc=0xFFFF`, INSTR_BYTES=2 reads 0xFFFF then 0x0000.

## Timing
- Reset values:
  - state FETCHING, `pc=RESET_PC`, `instruction=0`, `fetch_complete=0`
  - `issue_idx=cap_idx=0`, `cap_pending=0`
  - `mem_rd_en=1`, `mem_addr=RESET_PC` (combinational; a read during reset is harmless)
- Cycle numbering: cycle 0 is the cycle in which an op is sampled, or the last reset cycle.
  - Cycles 1..N: issue byte i−1.
  - Cycles 2..N+1: capture.
  - Cycle N+2: `fetch_complete=1` and `instruction` valid.
  - N=2: complete 4 cycles after the op edge.
- `fetch_complete` drops in the cycle after a FETCH_INC_PC or FETCH_LOAD_PC is accepted in DONE.
- Reset asserted mid-fetch: returns immediately to the reset values. Any in-flight read data is discarded.
- Restart clears `cap_pending`, so a read issued in the cycle before a restart is never captured.

## Configuration
- `FETCH_BRANCH_ABORT_EN` defined:
  - FETCH_LOAD_PC during FETCHING aborts the current fetch.
  - `pc <= new_pc`, restart with the normal timing from that edge; the stale in-flight byte is dropped.
- Not defined:
  - Every op other than FETCH_NOP is ignored during FETCHING.
  - Control must wait for `fetch_complete` before issuing an op.

## Structure
- `cpu_common` package:
  - owns `fetch_operation_t`, adding FETCH_LOAD_PC
  - owns new `fetch_state_t` {FETCHING, DONE}
  - exports `INSTR_BYTES` and the default PC width as shared constants
- Single module, no sub-modules. The PC register and byte-lane assembly are simple enough to stay inline.

## Test plan
- Reset: memory 0x0000=0xA1, 0x0001=0xB2, RESET_PC=0 → `fetch_complete=1` in cycle 4, `instruction=0xA1B2`, `pc=0`.
- Sequential fetch: FETCH_INC_PC in DONE, 0x0002=0xC3, 0x0003=0xD4 → `fetch_complete` low next cycle, then `instruction=0xC3D4`, `pc=2` four cycles after the op.
- Jump: FETCH_LOAD_PC with `new_pc=0x1234` → `mem_addr` 0x1234 then 0x1235, `pc=0x1234`, correct data.
- Wrap: `pc=0xFFFF` → reads 0xFFFF and 0x0000; after FETCH_INC_PC, `pc=0x0001`.
- Hold: 20 cycles of FETCH_NOP in DONE → `mem_rd_en=0`, outputs stable.
- Branch mid-fetch: FETCH_LOAD_PC(0x0040) in cycle 2.
  - With FETCH_BRANCH_ABORT_EN: `instruction` holds the bytes at 0x0040/0x0041 and contains no stale byte.
  - Without: the op is ignored and the original fetch completes.
  - A separate case asserts reset mid-fetch and checks the reset values.
